// File: rtl/alu_rr_sched.sv
// alu_rr_sched: two-requester round-robin front end for a shared 1-cycle ALU.
// Each requester may have at most one op in flight. Its result lands in a
// private 1-entry response slot. A saturating overflow counter is kept per
// requester.
module alu_rr_sched #(
  parameter int DATA_W = 8,
  parameter int INST_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [INST_W-1:0] i_req0_inst,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [INST_W-1:0] i_req1_inst,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,

  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp0_overflow,

  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic              o_rsp1_overflow,

  output logic              o_alu_valid,
  output logic [INST_W-1:0] o_alu_inst,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_alu_overflow,

  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_ovf_cnt0,
  output logic [CNT_W-1:0]  o_ovf_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic inflight_v;
  logic inflight_tag;
  logic last_grant;

  logic elig0, elig1;
  logic cand0, cand1;
  logic grant0, grant1, grant_any;
  logic capture0, capture1;
  logic pop0, pop1;

  // Eligibility, round-robin arbitration and the combinational ALU issue mux.
  // A requester whose slot is full may still issue if the slot drains this
  // cycle, because its result cannot land before the next edge.
  always_comb begin
    elig0     = !(inflight_v && !inflight_tag) && (!o_rsp0_valid || i_rsp0_ready);
    elig1     = !(inflight_v &&  inflight_tag) && (!o_rsp1_valid || i_rsp1_ready);
    cand0     = i_req0_valid && elig0;
    cand1     = i_req1_valid && elig1;
    grant0    = cand0 && (!cand1 || last_grant);
    grant1    = cand1 && (!cand0 || !last_grant);
    grant_any = grant0 || grant1;

    o_req0_ready = elig0 && grant0;
    o_req1_ready = elig1 && grant1;

    o_alu_valid = grant_any;
    o_alu_inst  = '0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    if (grant0) begin
      o_alu_inst = i_req0_inst;
      o_alu_a    = i_req0_a;
      o_alu_b    = i_req0_b;
    end else if (grant1) begin
      o_alu_inst = i_req1_inst;
      o_alu_a    = i_req1_a;
      o_alu_b    = i_req1_b;
    end

    capture0 = inflight_v && !inflight_tag;
    capture1 = inflight_v &&  inflight_tag;
    pop0     = o_rsp0_valid && i_rsp0_ready;
    pop1     = o_rsp1_valid && i_rsp1_ready;
  end

  // In-flight tag and round-robin pointer; the pointer only moves on a grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_v   <= 1'b0;
      inflight_tag <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      inflight_v   <= grant_any;
      inflight_tag <= grant1;
      if (grant_any) last_grant <= grant1;
    end
  end

  // Response slot 0: filled from the ALU one cycle after issue, held until popped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp0_valid    <= 1'b0;
      o_rsp0_data     <= '0;
      o_rsp0_overflow <= 1'b0;
    end else if (capture0) begin
      o_rsp0_valid    <= 1'b1;
      o_rsp0_data     <= i_alu_data;
      o_rsp0_overflow <= i_alu_overflow;
    end else if (pop0) begin
      o_rsp0_valid    <= 1'b0;
    end
  end

  // Response slot 1: same behaviour as slot 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp1_valid    <= 1'b0;
      o_rsp1_data     <= '0;
      o_rsp1_overflow <= 1'b0;
    end else if (capture1) begin
      o_rsp1_valid    <= 1'b1;
      o_rsp1_data     <= i_alu_data;
      o_rsp1_overflow <= i_alu_overflow;
    end else if (pop1) begin
      o_rsp1_valid    <= 1'b0;
    end
  end

  // Saturating overflow counters; clear takes priority over a same-edge increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf_cnt0 <= '0;
      o_ovf_cnt1 <= '0;
    end else if (i_clr_cnt) begin
      o_ovf_cnt0 <= '0;
      o_ovf_cnt1 <= '0;
    end else begin
      if (capture0 && i_alu_overflow && (o_ovf_cnt0 != CNT_MAX))
        o_ovf_cnt0 <= o_ovf_cnt0 + 1'b1;
      if (capture1 && i_alu_overflow && (o_ovf_cnt1 != CNT_MAX))
        o_ovf_cnt1 <= o_ovf_cnt1 + 1'b1;
    end
  end

endmodule
